// File: rtl/hangman_pkg.sv
// Shared constants for the hangman keyboard path: ASCII key codes, PS/2 prefix bytes
// and the PS/2 frame receiver state encoding.
package hangman_pkg;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_ENTER = 8'h0A;
  localparam logic [7:0] KEY_BKSP  = 8'h08;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_key_source_if.sv
// Key source signal bundle: raw PS/2 pins in, level key code plus strobe/error pulses out.
// master = ps2_key_source, slave = board pins / key consumers.
interface ps2_key_source_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] key;
  logic       key_strobe;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_dat,
    output key, key_strobe, frame_err
  );

  modport slave (
    output ps2_clk, ps2_dat,
    input  key, key_strobe, frame_err
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM, idle timeout.
// byte_valid_o/err_o pulse 1 clock after the synchronised stop edge; no backpressure. Option: PS2_PARITY_CHECK_EN.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o
);
  import hangman_pkg::*;

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SS-1:0] clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  logic          fall, dat_s, stop_ok;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;

  // Lines idle high, so synchronisers reset to 1 to avoid a false edge out of reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SS-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SS-2:0], ps2_dat_i};
      clk_prev_q <= clk_sync_q[SS-1];
    end
  end

  assign fall  = clk_prev_q & ~clk_sync_q[SS-1];
  assign dat_s = dat_sync_q[SS-1];

`ifdef PS2_PARITY_CHECK_EN
  assign stop_ok = dat_s & (^{shift_q, par_q});
`else
  assign stop_ok = dat_s;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      // An edge always wins over a coincident timeout.
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          vld_d   = stop_ok;
          err_d   = ~stop_ok;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d   = IDLE;
        bit_cnt_d = 3'd0;
        tmo_d     = '0;
        err_d     = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = vld_q;
  assign err_o        = err_q;

endmodule

// File: rtl/ps2_key_source.sv
// PS/2 set-2 make/break decoder presenting the held key as level ASCII (8'h00 = none).
// key/key_strobe update 2 clocks after the synchronised stop edge; no backpressure. Option: PS2_PARITY_CHECK_EN.
module ps2_key_source #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input logic             clock,
  input logic             resetn,
  ps2_key_source_if.master kif
);
  import hangman_pkg::*;

  logic [7:0] rx_byte;
  logic       rx_vld, rx_err;
  logic [7:0] ascii;
  logic [7:0] key_q, key_d;
  logic       strobe_q, strobe_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clock        (clock),
    .resetn       (resetn),
    .ps2_clk_i    (kif.ps2_clk),
    .ps2_dat_i    (kif.ps2_dat),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_vld),
    .err_o        (rx_err)
  );

  // Extended codes map only keypad Enter; everything else under E0 is ignored.
  always_comb begin
    ascii = KEY_NONE;
    if (ext_q) begin
      if (rx_byte == 8'h5A) ascii = KEY_ENTER;
    end else begin
      case (rx_byte)
        8'h1C: ascii = 8'h41;  8'h32: ascii = 8'h42;  8'h21: ascii = 8'h43;
        8'h23: ascii = 8'h44;  8'h24: ascii = 8'h45;  8'h2B: ascii = 8'h46;
        8'h34: ascii = 8'h47;  8'h33: ascii = 8'h48;  8'h43: ascii = 8'h49;
        8'h3B: ascii = 8'h4A;  8'h42: ascii = 8'h4B;  8'h4B: ascii = 8'h4C;
        8'h3A: ascii = 8'h4D;  8'h31: ascii = 8'h4E;  8'h44: ascii = 8'h4F;
        8'h4D: ascii = 8'h50;  8'h15: ascii = 8'h51;  8'h2D: ascii = 8'h52;
        8'h1B: ascii = 8'h53;  8'h2C: ascii = 8'h54;  8'h3C: ascii = 8'h55;
        8'h2A: ascii = 8'h56;  8'h1D: ascii = 8'h57;  8'h22: ascii = 8'h58;
        8'h35: ascii = 8'h59;  8'h1A: ascii = 8'h5A;
        8'h5A: ascii = KEY_ENTER;
        8'h66: ascii = KEY_BKSP;
        default: ascii = KEY_NONE;
      endcase
    end
  end

  always_comb begin
    key_d    = key_q;
    strobe_d = 1'b0;
    brk_d    = brk_q;
    ext_d    = ext_q;
    if (rx_vld) begin
      if (rx_byte == PS2_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (ascii != KEY_NONE) begin
          if (brk_q) begin
            if (ascii == key_q) key_d = KEY_NONE;
          end else begin
            key_d    = ascii;
            strobe_d = (ascii != key_q);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_q    <= KEY_NONE;
      strobe_q <= 1'b0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
    end else begin
      key_q    <= key_d;
      strobe_q <= strobe_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
    end
  end

  assign kif.key        = key_q;
  assign kif.key_strobe = strobe_q;
  assign kif.frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_key_source.sv
// Directed bench for ps2_key_source: bit-banged PS/2 frames, pulse monitor, per-scenario checks.
module tb_ps2_key_source;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  always #10 clock = ~clock;

  ps2_key_source_if kif();

  ps2_key_source #(
    .TIMEOUT_CYCLES (50000),
    .SYNC_STAGES    (2)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .kif    (kif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int last_strobe_cyc = 0;
  int last_err_cyc = 0;
  int last_fall_cyc = 0;
  int stop_fall_cyc = 0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (kif.key_strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      last_strobe_cyc = cyc;
    end
    if (kif.frame_err === 1'b1) begin
      err_cnt = err_cnt + 1;
      last_err_cyc = cyc;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: bench still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    kif.ps2_dat = b;
    tick(2);
    kif.ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    tick(4);
    kif.ps2_clk = 1'b1;
    tick(2);
  endtask

  task automatic send_frame_x(input logic [7:0] d, input logic flip_par, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ flip_par);
    send_bit(stop_b);
    stop_fall_cyc = last_fall_cyc;
    kif.ps2_dat = 1'b1;
    tick(6);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_frame_x(d, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    kif.ps2_clk = 1'b1;
    kif.ps2_dat = 1'b1;
    resetn = 1'b0;
    tick(3);
    n_tests++;
    if (kif.key !== 8'h00) begin n_fail++; $display("FAIL reset_key: got %h expected 00", kif.key); end
    n_tests++;
    if (kif.key_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", kif.key_strobe); end
    n_tests++;
    if (kif.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", kif.frame_err); end
    resetn = 1'b1;
    tick(3);
  endtask

  task automatic test_make_break();
    int s0;
    s0 = strobe_cnt;
    send_frame(8'h1C);
    n_tests++;
    if (kif.key !== 8'h41) begin n_fail++; $display("FAIL make_A_key: got %h expected 41", kif.key); end
    n_tests++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL make_A_strobes: got %0d expected 1", strobe_cnt - s0); end
    n_tests++;
    if (last_strobe_cyc - stop_fall_cyc !== 4) begin
      n_fail++; $display("FAIL make_A_latency: got %0d expected 4", last_strobe_cyc - stop_fall_cyc);
    end
    send_frame(8'hF0);
    n_tests++;
    if (kif.key !== 8'h41) begin n_fail++; $display("FAIL break_prefix_key: got %h expected 41", kif.key); end
    send_frame(8'h1C);
    n_tests++;
    if (kif.key !== 8'h00) begin n_fail++; $display("FAIL break_A_key: got %h expected 00", kif.key); end
    n_tests++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL break_A_strobes: got %0d expected 1", strobe_cnt - s0); end
  endtask

  task automatic test_enter_bksp();
    int s0;
    s0 = strobe_cnt;
    send_frame(8'h5A);
    n_tests++;
    if (kif.key !== 8'h0A) begin n_fail++; $display("FAIL enter_key: got %h expected 0a", kif.key); end
    send_frame(8'hF0); send_frame(8'h5A);
    n_tests++;
    if (kif.key !== 8'h00) begin n_fail++; $display("FAIL enter_break: got %h expected 00", kif.key); end
    send_frame(8'hE0); send_frame(8'h5A);
    n_tests++;
    if (kif.key !== 8'h0A) begin n_fail++; $display("FAIL kp_enter_key: got %h expected 0a", kif.key); end
    send_frame(8'hE0); send_frame(8'h75);
    n_tests++;
    if (kif.key !== 8'h0A) begin n_fail++; $display("FAIL ext_arrow_make: got %h expected 0a", kif.key); end
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    n_tests++;
    if (kif.key !== 8'h0A) begin n_fail++; $display("FAIL ext_arrow_break: got %h expected 0a", kif.key); end
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h5A);
    n_tests++;
    if (kif.key !== 8'h00) begin n_fail++; $display("FAIL kp_enter_break: got %h expected 00", kif.key); end
    send_frame(8'h66);
    n_tests++;
    if (kif.key !== 8'h08) begin n_fail++; $display("FAIL bksp_key: got %h expected 08", kif.key); end
    send_frame(8'h76);
    n_tests++;
    if (kif.key !== 8'h08) begin n_fail++; $display("FAIL unmapped_make: got %h expected 08", kif.key); end
    send_frame(8'hF0); send_frame(8'h66);
    n_tests++;
    if (kif.key !== 8'h00) begin n_fail++; $display("FAIL bksp_break: got %h expected 00", kif.key); end
    n_tests++;
    if (strobe_cnt - s0 !== 3) begin n_fail++; $display("FAIL enter_strobes: got %0d expected 3", strobe_cnt - s0); end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = strobe_cnt;
    send_frame(8'h1C); send_frame(8'h1C); send_frame(8'h1C);
    n_tests++;
    if (kif.key !== 8'h41) begin n_fail++; $display("FAIL typematic_key: got %h expected 41", kif.key); end
    n_tests++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL typematic_strobes: got %0d expected 1", strobe_cnt - s0); end
    send_frame(8'h32);
    n_tests++;
    if (kif.key !== 8'h42) begin n_fail++; $display("FAIL replace_key: got %h expected 42", kif.key); end
    n_tests++;
    if (strobe_cnt - s0 !== 2) begin n_fail++; $display("FAIL replace_strobes: got %0d expected 2", strobe_cnt - s0); end
    send_frame(8'hF0); send_frame(8'h1C);
    n_tests++;
    if (kif.key !== 8'h42) begin n_fail++; $display("FAIL stale_break_key: got %h expected 42", kif.key); end
    send_frame(8'hF0); send_frame(8'h32);
    n_tests++;
    if (kif.key !== 8'h00) begin n_fail++; $display("FAIL release_B_key: got %h expected 00", kif.key); end
  endtask

  task automatic test_frame_errors();
    int e0;
    logic [7:0] exp_key;
    int exp_err;
`ifdef PS2_PARITY_CHECK_EN
    exp_key = 8'h00;
    exp_err = 1;
`else
    exp_key = 8'h41;
    exp_err = 0;
`endif
    e0 = err_cnt;
    send_frame_x(8'h1C, 1'b1, 1'b1);
    n_tests++;
    if (kif.key !== exp_key) begin n_fail++; $display("FAIL bad_parity_key: got %h expected %h", kif.key, exp_key); end
    n_tests++;
    if (err_cnt - e0 !== exp_err) begin n_fail++; $display("FAIL bad_parity_err: got %0d expected %0d", err_cnt - e0, exp_err); end
    send_frame(8'hF0); send_frame(8'h1C);
    n_tests++;
    if (kif.key !== 8'h00) begin n_fail++; $display("FAIL parity_cleanup_key: got %h expected 00", kif.key); end
    e0 = err_cnt;
    send_frame_x(8'h32, 1'b0, 1'b0);
    n_tests++;
    if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL bad_stop_err: got %0d expected 1", err_cnt - e0); end
    n_tests++;
    if (kif.key !== 8'h00) begin n_fail++; $display("FAIL bad_stop_key: got %h expected 00", kif.key); end
  endtask

  task automatic test_timeout();
    int e0, f0, s0;
    e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    f0 = last_fall_cyc;
    kif.ps2_dat = 1'b1;
    for (int i = 0; i < 60000 && err_cnt == e0; i++) tick(1);
    n_tests++;
    if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL timeout_err: got %0d expected 1", err_cnt - e0); end
    n_tests++;
    if (last_err_cyc - f0 !== 50003) begin
      n_fail++; $display("FAIL timeout_delay: got %0d expected 50003", last_err_cyc - f0);
    end
    s0 = strobe_cnt;
    send_frame(8'h24);
    n_tests++;
    if (kif.key !== 8'h45) begin n_fail++; $display("FAIL after_timeout_key: got %h expected 45", kif.key); end
    n_tests++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL after_timeout_strobe: got %0d expected 1", strobe_cnt - s0); end
    send_frame(8'hF0); send_frame(8'h24);
  endtask

  task automatic test_reset_midframe();
    int e0;
    send_frame(8'h1C);
    n_tests++;
    if (kif.key !== 8'h41) begin n_fail++; $display("FAIL pre_reset_key: got %h expected 41", kif.key); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    e0 = err_cnt;
    #3;
    resetn = 1'b0;
    #1;
    n_tests++;
    if (kif.key !== 8'h00) begin n_fail++; $display("FAIL async_reset_key: got %h expected 00", kif.key); end
    kif.ps2_dat = 1'b1;
    tick(3);
    resetn = 1'b1;
    tick(3);
    send_frame(8'h2D);
    n_tests++;
    if (kif.key !== 8'h52) begin n_fail++; $display("FAIL post_reset_key: got %h expected 52", kif.key); end
    n_tests++;
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL post_reset_err: got %0d expected 0", err_cnt - e0); end
  endtask

  initial begin
    kif.ps2_clk = 1'b1;
    kif.ps2_dat = 1'b1;
    test_reset();
    test_make_break();
    test_enter_bksp();
    test_back_to_back();
    test_frame_errors();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
